// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: D = x - y - B0, resolved LSB-first one bit per clock through a
// single full-subtractor cell, with registered borrow-out, signed overflow and done strobe.
module serial_subtractor_4bit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             B0,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             ovf
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] x_sr_q, x_sr_d;
   logic [WIDTH-1:0] y_sr_q, y_sr_d;
   logic [WIDTH-1:0] r_sr_q, r_sr_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             xs_q, xs_d;
   logic             ys_q, ys_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             last;
   logic             bit_a, bit_b;
   logic             diff_bit;
   logic             borrow_nxt;
   logic [WIDTH-1:0] result;

   // Full-subtractor cell operating on the current LSBs.
   assign bit_a      = x_sr_q[0];
   assign bit_b      = y_sr_q[0];
   assign diff_bit   = bit_a ^ bit_b ^ borrow_q;
   assign borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
   assign result     = {diff_bit, r_sr_q[WIDTH-1:1]};

   assign accept = start & ready;
   assign last   = (state_q == StRun) && (cnt_q == CntLast);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (cnt_q == CntLast) state_d = StDone;
         StDone:  state_d = start ? StRun : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      unique case (state_q)
         StIdle:  ready = 1'b1;
         StRun:   busy  = 1'b1;
         StDone: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   // Datapath next-state
   always_comb begin
      x_sr_d   = x_sr_q;
      y_sr_d   = y_sr_q;
      r_sr_d   = r_sr_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      xs_d     = xs_q;
      ys_d     = ys_q;
      d_d      = d_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      if (accept) begin
         x_sr_d   = x;
         y_sr_d   = y;
         r_sr_d   = '0;
         borrow_d = B0;
         cnt_d    = '0;
         xs_d     = x[WIDTH-1];
         ys_d     = y[WIDTH-1];
      end else if (state_q == StRun) begin
         x_sr_d   = x_sr_q >> 1;
         y_sr_d   = y_sr_q >> 1;
         r_sr_d   = result;
         borrow_d = borrow_nxt;
         cnt_d    = cnt_q + 1'b1;
      end
      // The MSB of the result is the bit produced in the last cycle.
      if (last) begin
         d_d    = result;
         bout_d = borrow_nxt;
         ovf_d  = (xs_q ^ ys_q) & (xs_q ^ diff_bit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_sr_q   <= '0;
         y_sr_q   <= '0;
         r_sr_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         xs_q     <= 1'b0;
         ys_q     <= 1'b0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         x_sr_q   <= x_sr_d;
         y_sr_q   <= y_sr_d;
         r_sr_q   <= r_sr_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         xs_q     <= xs_d;
         ys_q     <= ys_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign D    = d_q;
   assign Bout = bout_q;
   assign ovf  = ovf_q;

endmodule
